// File: rtl/dma_streamer.sv
// Splits one DMA descriptor into AXI-legal bursts (MAX_BEATS, 4 KB boundary, FIXED length cap).
// Latency: 2 cycles from an accepted start to the first request; requests hold until req_ready_i.
module dma_streamer #(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_active_i,
    input  logic        dma_abort_i,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] bytes_i,
    input  logic        mode_fixed_i,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    output logic [7:0]  req_alen_o,
    output logic [2:0]  req_size_o,
    output logic [3:0]  req_strb_o,
    output logic        req_mode_o,
    input  logic        req_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        cfg_err_o,
    output logic [15:0] burst_cnt_o
);

    typedef enum logic [1:0] {IDLE, CALC, REQ, DONE} state_t;

    localparam logic [31:0] CAP_INCR  = 32'(MAX_BEATS);
    localparam logic [31:0] CAP_FIXED = (MAX_BEATS < 16) ? 32'(MAX_BEATS) : 32'd16;

    state_t      state, state_nxt;
    logic [31:0] addr;
    logic [31:0] rem_beats;
    logic [31:0] beats;
    logic [1:0]  tail;
    logic        mode;

    logic        accept;
    logic        bad_desc;
    logic        hs;
    logic [31:0] rem_after;
    logic [10:0] bnd_words;
    logic [31:0] lim;
    logic [31:0] beats_calc;
    logic [3:0]  strb_calc;

    assign req_size_o = 3'b010;
    assign accept     = (state == IDLE) && start_i && dma_active_i;
    assign bad_desc   = (addr_i[1:0] != 2'b00) || (bytes_i == 32'd0);
    assign hs         = (state == REQ) && req_ready_i;
    assign rem_after  = rem_beats - beats;
    // Words left before the next 4 KB page; 1..1024 for a word-aligned address.
    assign bnd_words  = 11'd1024 - {1'b0, addr[11:2]};

    always_comb begin
        lim = mode ? CAP_FIXED : CAP_INCR;
        if (!mode && ({21'd0, bnd_words} < lim)) begin
            lim = {21'd0, bnd_words};
        end
        beats_calc = (rem_beats < lim) ? rem_beats : lim;
        strb_calc  = 4'hF;
        if ((beats_calc == rem_beats) && (tail != 2'b00)) begin
            case (tail)
                2'd1:    strb_calc = 4'h1;
                2'd2:    strb_calc = 4'h3;
                default: strb_calc = 4'h7;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_valid_o = (state == REQ);
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
        case (state)
            IDLE: if (accept) state_nxt = bad_desc ? DONE : CALC;
            CALC: state_nxt = dma_abort_i ? DONE : REQ;
            REQ: begin
                if (hs) begin
                    state_nxt = (dma_abort_i || (rem_after == 32'd0)) ? DONE : CALC;
                end else if (dma_abort_i) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!dma_active_i) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            rem_beats   <= '0;
            beats       <= '0;
            tail        <= '0;
            mode        <= 1'b0;
            req_addr_o  <= '0;
            req_alen_o  <= '0;
            req_strb_o  <= '0;
            req_mode_o  <= 1'b0;
            burst_cnt_o <= '0;
            cfg_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                cfg_err_o <= (addr_i[1:0] != 2'b00);
                if (!bad_desc) begin
                    addr        <= addr_i;
                    mode        <= mode_fixed_i;
                    rem_beats   <= {2'b00, bytes_i[31:2]} + {31'd0, |bytes_i[1:0]};
                    tail        <= bytes_i[1:0];
                    burst_cnt_o <= '0;
                end
            end
            if (state == CALC) begin
                beats      <= beats_calc;
                req_addr_o <= addr;
                req_alen_o <= 8'(beats_calc - 32'd1);
                req_strb_o <= strb_calc;
                req_mode_o <= mode;
            end
            if (hs) begin
                burst_cnt_o <= burst_cnt_o + 16'd1;
                rem_beats   <= rem_after;
                if (!mode) begin
                    addr <= addr + (beats << 2);
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_streamer.sv
// Bench for dma_streamer: randomized descriptors and ready patterns checked against a loop-level burst model.
module tb_dma_streamer;

    localparam int MB = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  alen;
        logic [3:0]  strb;
        logic        mode;
    } burst_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dma_active_i = 1'b1;
    logic        dma_abort_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] bytes_i = '0;
    logic        mode_fixed_i = 1'b0;
    logic        req_ready_i = 1'b0;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic [7:0]  req_alen_o;
    logic [2:0]  req_size_o;
    logic [3:0]  req_strb_o;
    logic        req_mode_o;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;
    logic [15:0] burst_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    burst_t exp_q[$];
    burst_t obs_q[$];

    always #5 clk = ~clk;

    dma_streamer #(.MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst), .dma_active_i(dma_active_i), .dma_abort_i(dma_abort_i),
        .start_i(start_i), .addr_i(addr_i), .bytes_i(bytes_i), .mode_fixed_i(mode_fixed_i),
        .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_alen_o(req_alen_o),
        .req_size_o(req_size_o), .req_strb_o(req_strb_o), .req_mode_o(req_mode_o),
        .req_ready_i(req_ready_i), .busy_o(busy_o), .done_o(done_o),
        .cfg_err_o(cfg_err_o), .burst_cnt_o(burst_cnt_o)
    );

    // Reference: walk the descriptor word by word budget, taking the largest legal burst each time.
    task automatic model(input logic [31:0] a, input logic [31:0] bytes, input logic fx);
        longint rem, lim, b;
        int     t;
        burst_t e;
        exp_q.delete();
        if (a[1:0] != 2'b00 || bytes == 0) return;
        rem = (longint'(bytes) + 3) / 4;
        t   = int'(bytes % 4);
        while (rem > 0) begin
            lim = fx ? ((MB < 16) ? MB : 16) : MB;
            if (!fx && (4096 - longint'(a % 4096)) / 4 < lim) lim = (4096 - longint'(a % 4096)) / 4;
            b = (rem < lim) ? rem : lim;
            e.addr = a;
            e.alen = 8'(b - 1);
            e.strb = (b == rem && t != 0) ? 4'((1 << t) - 1) : 4'hF;
            e.mode = fx;
            exp_q.push_back(e);
            rem -= b;
            if (!fx) a = a + 32'(b * 4);
        end
    endtask

    task automatic drive_desc(input logic [31:0] a, input logic [31:0] bytes, input logic fx,
                              input int rdy_pct, input bit noise, output int first_vld,
                              output int done_cnt, output logic [15:0] cnt_at_done,
                              output logic err_at_done, output bit timeout);
        int tail_cyc;
        burst_t o;
        obs_q.delete();
        first_vld = -1; done_cnt = 0; timeout = 1; tail_cyc = -1;
        cnt_at_done = '0; err_at_done = 1'b0;
        @(negedge clk);
        start_i = 1'b1; addr_i = a; bytes_i = bytes; mode_fixed_i = fx;
        req_ready_i = ($urandom_range(0, 99) < rdy_pct);
        for (int cyc = 1; cyc < 4000; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (noise && busy_o && $urandom_range(0, 3) == 0) begin
                start_i = 1'b1; addr_i = $urandom; bytes_i = $urandom; mode_fixed_i = $urandom_range(0, 1);
            end
            req_ready_i = ($urandom_range(0, 99) < rdy_pct);
            if (req_valid_o && first_vld < 0) first_vld = cyc;
            if (req_valid_o && req_ready_i) begin
                o.addr = req_addr_o; o.alen = req_alen_o; o.strb = req_strb_o; o.mode = req_mode_o;
                obs_q.push_back(o);
            end
            if (done_o) begin
                done_cnt++;
                if (tail_cyc < 0) begin
                    cnt_at_done = burst_cnt_o; err_at_done = cfg_err_o; timeout = 0; tail_cyc = cyc + 3;
                end
            end
            if (cyc == tail_cyc) break;
        end
        start_i = 1'b0; req_ready_i = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_valid_o) begin ok = 1; break; end
        end
    endtask

    task automatic start_pulse(input logic [31:0] a, input logic [31:0] bytes, input logic fx);
        @(negedge clk);
        start_i = 1'b1; addr_i = a; bytes_i = bytes; mode_fixed_i = fx;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_valid_o, busy_o, done_o, cfg_err_o, burst_cnt_o} !== 20'd0) begin
            n_bad++; $display("FAIL reset_ctrl: got %h want 0", {req_valid_o, busy_o, done_o, cfg_err_o, burst_cnt_o});
        end
        n_cmp++;
        if ({req_addr_o, req_alen_o, req_strb_o, req_mode_o, req_size_o} !== {45'd0, 3'b010}) begin
            n_bad++; $display("FAIL reset_req: addr %h alen %h strb %h mode %b size %b",
                              req_addr_o, req_alen_o, req_strb_o, req_mode_o, req_size_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] t_addr[6] = '{32'h1000, 32'h0FF0, 32'h2000, 32'h3000, 32'hFFFF_FFF0, 32'h4004};
        logic [31:0] t_bytes[6] = '{256, 64, 10, 160, 64, 7};
        logic        t_fx[6] = '{0, 0, 0, 1, 0, 1};
        int          t_n[6] = '{4, 2, 1, 3, 2, 1};
        int fv, dc; logic [15:0] cnt; logic err; bit to;
        for (int k = 0; k < 6; k++) begin
            model(t_addr[k], t_bytes[k], t_fx[k]);
            drive_desc(t_addr[k], t_bytes[k], t_fx[k], (k == 0) ? 100 : 60, 1'b0, fv, dc, cnt, err, to);
            n_cmp++;
            if (to || dc != 1) begin n_bad++; $display("FAIL dir%0d_done: timeout %0d pulses %0d want 1", k, to, dc); end
            n_cmp++;
            if (fv != 2) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want 2", k, fv); end
            n_cmp++;
            if (obs_q.size() != t_n[k] || cnt !== 16'(t_n[k])) begin
                n_bad++; $display("FAIL dir%0d_count: bursts %0d cnt %0d want %0d", k, obs_q.size(), cnt, t_n[k]);
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL dir%0d_burst%0d: got %h/%h/%h/%b want %h/%h/%h/%b", k, i,
                        obs_q[i].addr, obs_q[i].alen, obs_q[i].strb, obs_q[i].mode,
                        exp_q[i].addr, exp_q[i].alen, exp_q[i].strb, exp_q[i].mode);
                end
            end
        end
    endtask

    task automatic test_random;
        int fv, dc; logic [15:0] cnt; logic err; bit to;
        logic [31:0] a, r; logic [31:0] by; logic fx;
        for (int k = 0; k < 40; k++) begin
            r = $urandom;
            if (k % 2 == 0) a = {r[31:12], 12'h000} - 32'(4 * $urandom_range(0, 40));
            else a = {r[31:2], 2'b00};
            by = $urandom_range(1, 700);
            fx = $urandom_range(0, 1);
            model(a, by, fx);
            drive_desc(a, by, fx, $urandom_range(20, 100), 1'b1, fv, dc, cnt, err, to);
            n_cmp++;
            if (to || dc != 1 || obs_q.size() != exp_q.size() || cnt !== 16'(exp_q.size())) begin
                n_bad++; $display("FAIL rnd%0d_shape: timeout %0d pulses %0d bursts %0d cnt %0d want %0d",
                                  k, to, dc, obs_q.size(), cnt, exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL rnd%0d_burst%0d: got %h want %h (a=%h b=%0d fx=%b)",
                                      k, i, obs_q[i], exp_q[i], a, by, fx);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        burst_t snap; bit ok;
        model(32'h5000, 256, 1'b0);
        req_ready_i = 1'b0;
        start_pulse(32'h5000, 256, 1'b0);
        wait_valid(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL bp_valid: no request within bound"); end
        snap = {req_addr_o, req_alen_o, req_strb_o, req_mode_o};
        n_cmp++;
        if (snap !== exp_q[0]) begin n_bad++; $display("FAIL bp_first: got %h want %h", snap, exp_q[0]); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({req_addr_o, req_alen_o, req_strb_o, req_mode_o} !== snap || !req_valid_o || burst_cnt_o !== 16'd0) begin
                n_bad++; $display("FAIL bp_hold%0d: got %h vld %b cnt %0d want %h vld 1 cnt 0",
                                  i, {req_addr_o, req_alen_o, req_strb_o, req_mode_o}, req_valid_o, burst_cnt_o, snap);
            end
        end
        req_ready_i = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok || burst_cnt_o !== 16'd4) begin n_bad++; $display("FAIL bp_end: done %0d cnt %0d want 1/4", ok, burst_cnt_o); end
        req_ready_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort;
        bit ok;
        req_ready_i = 1'b0;
        start_pulse(32'h1000, 256, 1'b0);
        wait_valid(ok);
        dma_abort_i = 1'b1;
        @(negedge clk);
        dma_abort_i = 1'b0;
        n_cmp++;
        if (!ok || req_valid_o !== 1'b0 || done_o !== 1'b1 || burst_cnt_o !== 16'd0) begin
            n_bad++; $display("FAIL abort_req: seen %0d vld %b done %b cnt %0d want 1/0/1/0", ok, req_valid_o, done_o, burst_cnt_o);
        end
        @(negedge clk);
        n_cmp++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL abort_idle: done %b busy %b want 0/0", done_o, busy_o); end

        start_pulse(32'h1000, 256, 1'b0);
        wait_valid(ok);
        dma_abort_i = 1'b1; req_ready_i = 1'b1;
        @(negedge clk);
        dma_abort_i = 1'b0; req_ready_i = 1'b0;
        n_cmp++;
        if (!ok || burst_cnt_o !== 16'd1 || done_o !== 1'b1 || req_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL abort_hs: seen %0d cnt %0d done %b vld %b want 1/1/1/0", ok, burst_cnt_o, done_o, req_valid_o);
        end

        @(negedge clk);
        start_i = 1'b1; addr_i = 32'h1000; bytes_i = 256; mode_fixed_i = 1'b0; req_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; dma_abort_i = 1'b1;
        @(negedge clk);
        dma_abort_i = 1'b0;
        n_cmp++;
        if (req_valid_o !== 1'b0 || done_o !== 1'b1 || burst_cnt_o !== 16'd0) begin
            n_bad++; $display("FAIL abort_calc: vld %b done %b cnt %0d want 0/1/0", req_valid_o, done_o, burst_cnt_o);
        end
        req_ready_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_inactive;
        bit ok;
        start_pulse(32'h6000, 128, 1'b0);
        wait_valid(ok);
        dma_active_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!ok || req_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_bad++; $display("FAIL inactive_drop: seen %0d vld %b busy %b done %b want 1/0/0/0", ok, req_valid_o, busy_o, done_o);
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_bad++; $display("FAIL inactive_start: busy %b done %b want 0/0", busy_o, done_o);
        end
        dma_active_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        bit ok;
        req_ready_i = 1'b1;
        start_pulse(32'h7000, 512, 1'b0);
        wait_valid(ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_ready_i = 1'b0;
        n_cmp++;
        if (!ok || req_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || burst_cnt_o !== 16'd0) begin
            n_bad++; $display("FAIL mid_reset: seen %0d vld %b busy %b done %b cnt %0d want 1/0/0/0/0",
                              ok, req_valid_o, busy_o, done_o, burst_cnt_o);
        end
        @(negedge clk);
        n_cmp++;
        if (done_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset_done: got %b want 0", done_o); end
    endtask

    task automatic test_cfg_err;
        int fv, dc; logic [15:0] cnt; logic err; bit to;
        drive_desc(32'h1002, 16, 1'b0, 100, 1'b0, fv, dc, cnt, err, to);
        n_cmp++;
        if (to || dc != 1 || obs_q.size() != 0 || err !== 1'b1 || fv != -1) begin
            n_bad++; $display("FAIL misaligned: timeout %0d pulses %0d bursts %0d err %b want 0/1/0/1", to, dc, obs_q.size(), err);
        end
        n_cmp++;
        if (cfg_err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", cfg_err_o); end
        drive_desc(32'h2000, 0, 1'b0, 100, 1'b0, fv, dc, cnt, err, to);
        n_cmp++;
        if (to || dc != 1 || obs_q.size() != 0 || err !== 1'b0 || fv != -1) begin
            n_bad++; $display("FAIL zero_bytes: timeout %0d pulses %0d bursts %0d err %b want 0/1/0/0", to, dc, obs_q.size(), err);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_abort;
        test_inactive;
        test_mid_reset;
        test_cfg_err;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_streamer.md
Name: dma_streamer

Overview:
Descriptor-to-burst splitter that sits directly upstream of the DMA AXI interface block. It takes one transfer descriptor (start address, byte count, burst mode) and breaks it into AXI-legal bursts for the AXI interface's request port. One instance is used per direction: one drives read requests, one drives write requests. It respects MAX_BEATS, the 4 KB boundary rule, and the AXI FIXED-burst length limit, and generates the last-beat byte strobe.

Parameters:
MAX_BEATS, 16, maximum beats per burst, 1..256; FIXED bursts are additionally capped at 16.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dma_active_i  in  1  DMA enabled; low forces IDLE
dma_abort_i  in  1  abort current descriptor
start_i  in  1  descriptor start pulse, accepted only in IDLE
addr_i  in  32  descriptor start address; must be word aligned
bytes_i  in  32  descriptor byte count
mode_fixed_i  in  1  0=INCR, 1=FIXED
req_valid_o  out  1  burst request valid
req_addr_o  out  32  burst start address
req_alen_o  out  8  beats-1
req_size_o  out  3  always 3'b010 (4 bytes per beat)
req_strb_o  out  4  strobe applied to the burst's last beat
req_mode_o  out  1  0=INCR, 1=FIXED
req_ready_i  in  1  request accepted by the AXI interface (address-channel handshake)
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse when the descriptor finishes or aborts
cfg_err_o  out  1  sticky flag for a misaligned address; cleared by the next accepted start
burst_cnt_o  out  16  bursts issued for the current descriptor; wraps at 16 bits

Behaviour:
- Reset: state=IDLE; all outputs 0 except req_size_o=3'b010; internal addr and beat counters cleared.
- States: IDLE, CALC, REQ, DONE.
- IDLE:
  - Accept when start_i && dma_active_i.
  - addr_i[1:0]!=0: set cfg_err_o, go to DONE, issue no requests.
  - bytes_i==0: go to DONE, issue no requests.
  - Otherwise latch addr and mode; set rem_beats=ceil(bytes_i/4) and tail=bytes_i[1:0]; clear burst_cnt_o and cfg_err_o; go to CALC.
- CALC (1 cycle) computes:
  - bnd=(4096-addr[11:0])>>2 for INCR, infinite for FIXED.
  - cap=MAX_BEATS for INCR, min(MAX_BEATS,16) for FIXED.
  - beats=min(rem_beats,cap,bnd).
  - Registered outputs: req_alen_o=beats-1; req_addr_o=addr.
  - req_strb_o: equals (1<<tail)-1 when beats==rem_beats and tail!=0, else 4'hF.
  - Then go to REQ.
  - Latency: start_i to first req_valid_o is 2 cycles.
- REQ:
  - req_valid_o=1. All req_* fields stay stable until req_valid_o && req_ready_i.
  - On handshake: burst_cnt_o+=1; rem_beats-=beats; INCR also does addr+=beats*4 (FIXED keeps addr).
  - After handshake: rem_beats==0 goes to DONE, else CALC.
  - Minimum spacing between bursts is 2 cycles (valid is low during CALC).
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Abort:
  - dma_abort_i in CALC, or in REQ without a same-cycle handshake, drops req_valid_o the next cycle and goes to DONE.
  - A handshake in the same cycle as abort counts as issued, and the block still goes to DONE.
- dma_active_i low in any state: go to IDLE next cycle with req_valid_o=0 and no done_o pulse.
- start_i while busy_o=1 is ignored.
- Arithmetic:
  - All beat counts are 32-bit unsigned.
  - beats*4 is computed in 32 bits; address wraps modulo 2^32.
  - A single burst never crosses a 4 KB boundary in INCR mode.
- rst mid-descriptor aborts silently, with no done_o pulse.

Test Plan:
- addr=0x1000, bytes=256, INCR, ready tied 1:
  - 4 bursts at 0x1000/0x1040/0x1080/0x10C0, each alen=15, strb=F.
  - burst_cnt_o=4, then done_o pulse.
- addr=0x0FF0, bytes=64, INCR:
  - burst 0x0FF0 alen=3, then burst 0x1000 alen=11.
  - No burst crosses 0x1000.
- addr=0x2000, bytes=10:
  - Single burst alen=2, strb=4'h3, then done.
- FIXED mode, MAX_BEATS=32, addr=0x3000, bytes=160:
  - Bursts of alen=15, 15, 7, all at 0x3000, req_mode_o=1.
- Backpressure, abort and DONE edges:
  - ready held low 5 cycles: fields stay stable, no burst_cnt_o change.
  - Abort asserted in REQ: req_valid_o drops next cycle, done_o pulses, burst_cnt_o unchanged.
- Config errors:
  - addr=0x1002: cfg_err_o=1, done_o pulses, no requests.
  - bytes=0: done_o pulses with no requests and cfg_err_o=0.
